// File: rtl/uart_mcb_pkg.sv
// -----------------------------------------------------------------------------
// uart_mcb_pkg
// Shared definitions for the UART byte-stream to MCB port-0 burst writer.
//   mcb_state_t      : writer FSM encodings (ST_FILL, ST_PUSH, ST_CMD, ST_HALT)
//   MCB_INSTR_WRITE  : MCB command opcode for a write burst
//   MCB_INSTR_READ   : MCB command opcode for a read burst
//   MCB_MAX_BL       : largest burst the MCB accepts, in 32-bit words
//   lane_mask()      : byte-lane mask for a word holding 'fill' valid bytes
// -----------------------------------------------------------------------------
package uart_mcb_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_PUSH = 2'd1,
        ST_CMD  = 2'd2,
        ST_HALT = 2'd3
    } mcb_state_t;

    localparam logic [2:0]  MCB_INSTR_WRITE = 3'b000;
    localparam logic [2:0]  MCB_INSTR_READ  = 3'b001;
    localparam int unsigned MCB_MAX_BL      = 64;

    // Lanes at or above the fill level are masked (1 = do not write).
    function automatic logic [3:0] lane_mask(input logic [2:0] fill);
        logic [3:0] m;
        m = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            m[i] = (3'(i) >= fill);
        end
        return m;
    endfunction

endpackage

// File: rtl/uart_mcb_burst_writer_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
// Packs bytes little-endian into a 32-bit word and produces the lane mask.
// The word and mask outputs already include a byte accepted this cycle, so the
// parent can latch a full or partial word on the same edge the byte arrives.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   i_accept      : a byte is accepted this cycle
//   i_data [7:0]  : accepted byte
//   i_close       : close the current partial word (lane index returns to 0)
//   o_word [31:0] : packed word including this cycle's byte; unfilled lanes 0
//   o_mask [3:0]  : 1 = lane not filled
//   o_word_done   : lane 3 is being accepted this cycle
//   o_has_bytes   : at least one lane is filled, counting this cycle's byte
//   o_byte_idx    : registered lane index of the next byte
// -----------------------------------------------------------------------------
module byte_word_packer
    import uart_mcb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic [7:0]  i_data,
    input  logic        i_close,
    output logic [31:0] o_word,
    output logic [3:0]  o_mask,
    output logic        o_word_done,
    output logic        o_has_bytes,
    output logic [1:0]  o_byte_idx
);

    logic [3:0][7:0] r_lanes;
    logic [1:0]      r_byte_idx;
    logic [3:0][7:0] w_lanes;
    logic [2:0]      w_fill;
    logic [3:0]      w_mask;

    // NOTE: every output of this block gets a default before any conditional
    // update; a path that skips an assignment would infer a latch.
    always_comb begin
        w_lanes = r_lanes;
        if (i_accept) begin
            w_lanes[r_byte_idx] = i_data;
        end
        w_fill = {1'b0, r_byte_idx} + {2'b00, i_accept};
        w_mask = lane_mask(w_fill);
        o_word = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            o_word[8*i +: 8] = w_mask[i] ? 8'h00 : w_lanes[i];
        end
    end

    assign o_mask      = w_mask;
    assign o_word_done = i_accept && (r_byte_idx == 2'd3);
    assign o_has_bytes = (w_fill != 3'd0);
    assign o_byte_idx  = r_byte_idx;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order. The lane registers are
    // reset with the rest of the state so a stale lane never shows up as X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lanes    <= '0;
            r_byte_idx <= 2'd0;
        end else begin
            if (i_accept) begin
                r_lanes[r_byte_idx] <= i_data;
            end
            // Lane 3 wraps the index back to 0 by plain 2-bit overflow.
            if (i_close) begin
                r_byte_idx <= 2'd0;
            end else if (i_accept) begin
                r_byte_idx <= r_byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_mcb_burst_writer.sv
// -----------------------------------------------------------------------------
// uart_mcb_burst_writer
// Turns a received UART byte stream into MCB port-0 write bursts: bytes are
// packed into 32-bit words, pushed into the MCB write FIFO, and after
// BURST_LEN words (or a flush) one write command is issued at a linearly
// incrementing byte address that wraps to BASE_ADDR at ADDR_LIMIT.
// Optional build macro UART_MCB_BURST_WRITER_STATS_EN adds burst_count and
// addr_wrap status outputs.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   byte_valid/data/ready : byte input handshake
//   flush                 : close the current partial word/burst and issue it
//   busy                  : work in progress or data buffered
//   error                 : sticky MCB write-path fault
//   cmd_clk, wr_clk       : MCB port clocks (copies of clk)
//   cmd_en/instr/bl/byte_addr, cmd_full : MCB command port
//   wr_en/data/mask, wr_full            : MCB write-data port
//   wr_underrun, wr_error               : MCB write-path fault flags
//   burst_count, addr_wrap (STATS only) : commands issued, address wrapped
// -----------------------------------------------------------------------------
module uart_mcb_burst_writer
    import uart_mcb_pkg::*;
#(
    parameter int unsigned BURST_LEN  = 16,
    parameter logic [29:0] BASE_ADDR  = 30'h0000_0000,
    parameter logic [29:0] ADDR_LIMIT = 30'h0400_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        flush,
    output logic        busy,
    output logic        error,
    output logic        cmd_clk,
    output logic        wr_clk,
    output logic        cmd_en,
    output logic [2:0]  cmd_instr,
    output logic [5:0]  cmd_bl,
    output logic [29:0] cmd_byte_addr,
    input  logic        cmd_full,
    output logic        wr_en,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    input  logic        wr_full,
    input  logic        wr_underrun,
    input  logic        wr_error
`ifdef UART_MCB_BURST_WRITER_STATS_EN
    ,
    output logic [15:0] burst_count,
    output logic [0:0]  addr_wrap
`endif
);

    mcb_state_t  r_state;
    mcb_state_t  w_state_next;
    logic [6:0]  r_word_cnt;
    logic [29:0] r_cur_addr;
    logic        r_flush_pend;
    logic        r_byte_ready;
    logic        r_error;
    logic [31:0] r_wr_data;
    logic [3:0]  r_wr_mask;

    logic        w_fault;
    logic        w_flush_any;
    logic        w_accept;
    logic        w_latch;
    logic        w_close;
    logic        w_push;
    logic        w_cmd;
    logic        w_flush_drop;
    logic [31:0] w_word;
    logic [3:0]  w_mask;
    logic        w_word_done;
    logic        w_has_bytes;
    logic [1:0]  w_byte_idx;
    logic [30:0] w_addr_sum;
    logic        w_addr_wrap;

    assign w_fault     = wr_underrun | wr_error;
    assign w_flush_any = flush | r_flush_pend;
    // byte_ready is registered from the next state, so it is only ever high
    // while the FSM sits in ST_FILL.
    assign w_accept    = byte_valid && r_byte_ready;

    byte_word_packer u_packer (
        .clk         (clk),
        .rst         (reset),
        .i_accept    (w_accept),
        .i_data      (byte_data),
        .i_close     (w_close),
        .o_word      (w_word),
        .o_mask      (w_mask),
        .o_word_done (w_word_done),
        .o_has_bytes (w_has_bytes),
        .o_byte_idx  (w_byte_idx)
    );

    // One extra bit so an address sum that would overflow 30 bits still wraps.
    assign w_addr_sum  = {1'b0, r_cur_addr} + {22'd0, r_word_cnt, 2'b00};
    assign w_addr_wrap = (w_addr_sum >= {1'b0, ADDR_LIMIT});

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_close      = 1'b0;
        w_push       = 1'b0;
        w_cmd        = 1'b0;
        w_flush_drop = 1'b0;
        case (r_state)
            ST_FILL: begin
                if (w_word_done) begin
                    // Full word; any flush stays pending and closes the burst
                    // after this word is pushed.
                    w_latch      = 1'b1;
                    w_state_next = ST_PUSH;
                end else if (w_flush_any) begin
                    if (w_has_bytes) begin
                        w_latch      = 1'b1;
                        w_close      = 1'b1;
                        w_state_next = ST_PUSH;
                    end else if (r_word_cnt != 7'd0) begin
                        w_state_next = ST_CMD;
                    end else begin
                        w_flush_drop = 1'b1;
                    end
                end
            end
            ST_PUSH: begin
                if (!wr_full) begin
                    w_push = 1'b1;
                    if ((r_word_cnt + 7'd1 == 7'(BURST_LEN)) || w_flush_any) begin
                        w_state_next = ST_CMD;
                    end else begin
                        w_state_next = ST_FILL;
                    end
                end
            end
            ST_CMD: begin
                if (!cmd_full) begin
                    w_cmd        = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
        // A write-path fault overrides everything, including this cycle's strobes.
        if (w_fault) begin
            w_state_next = ST_HALT;
            w_latch      = 1'b0;
            w_close      = 1'b0;
            w_push       = 1'b0;
            w_cmd        = 1'b0;
            w_flush_drop = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_FILL;
            r_word_cnt   <= 7'd0;
            r_cur_addr   <= BASE_ADDR;
            r_flush_pend <= 1'b0;
            r_byte_ready <= 1'b0;
            r_error      <= 1'b0;
            r_wr_data    <= 32'h0000_0000;
            r_wr_mask    <= 4'b0000;
        end else begin
            r_state      <= w_state_next;
            r_byte_ready <= (w_state_next == ST_FILL);
            if (w_fault) begin
                r_error <= 1'b1;
            end
            if (w_latch) begin
                r_wr_data <= w_word;
                r_wr_mask <= w_mask;
            end
            if (w_cmd) begin
                r_word_cnt <= 7'd0;
            end else if (w_push) begin
                r_word_cnt <= r_word_cnt + 7'd1;
            end
            if (w_cmd || w_flush_drop) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != ST_HALT)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_cmd) begin
                r_cur_addr <= w_addr_wrap ? BASE_ADDR : w_addr_sum[29:0];
            end
        end
    end

`ifdef UART_MCB_BURST_WRITER_STATS_EN
    logic [15:0] r_burst_count;
    logic        r_addr_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_burst_count <= 16'h0000;
            r_addr_wrap   <= 1'b0;
        end else if (w_cmd) begin
            r_burst_count <= r_burst_count + 16'h0001;
            if (w_addr_wrap) begin
                r_addr_wrap <= 1'b1;
            end
        end
    end

    assign burst_count  = r_burst_count;
    assign addr_wrap[0] = r_addr_wrap;
`endif

    assign byte_ready    = r_byte_ready;
    assign busy          = (r_state != ST_FILL) || (w_byte_idx != 2'd0) || (r_word_cnt != 7'd0);
    assign error         = r_error;
    assign cmd_clk       = clk;
    assign wr_clk        = clk;
    assign cmd_en        = w_cmd;
    assign cmd_instr     = MCB_INSTR_WRITE;
    // word_cnt is 0 outside a burst; report 0 rather than an underflowed value.
    assign cmd_bl        = (r_word_cnt == 7'd0) ? 6'd0 : 6'(r_word_cnt - 7'd1);
    assign cmd_byte_addr = r_cur_addr;
    assign wr_en         = w_push;
    assign wr_data       = r_wr_data;
    assign wr_mask       = r_wr_mask;

endmodule

// File: doc/uart_mcb_burst_writer.md
Name: uart_mcb_burst_writer

Overview:
Byte-stream to MCB port-0 write-burst engine, sitting between uart_core's received-byte path and the lpddr_memory_controller p0 command and write ports. It packs incoming bytes little-endian into 32-bit words and pushes them into the MCB write FIFO. After BURST_LEN words, or on a flush request, it issues one write command at a linearly incrementing, wrapping byte address. A flush with a partial word is masked per byte lane.

Parameters:
BURST_LEN, 16, words per full burst; legal range 1..64.
BASE_ADDR, 30'h0000_0000, first byte address; must be 4-byte aligned.
ADDR_LIMIT, 30'h0400_0000, exclusive upper bound; the address wraps to BASE_ADDR at or above this value.

Ports:
clk  in  1  system clock (c3_clk0 domain)
reset  in  1  asynchronous, active-high reset
byte_valid  in  1  input byte present (for example, uart rx_done_tick)
byte_data  in  8  input byte
byte_ready  out  1  byte accepted on the cycle where byte_valid&&byte_ready
flush  in  1  single-cycle pulse: close the current partial word/burst and issue it
busy  out  1  high when not in ST_FILL, or when any word or byte is buffered
error  out  1  sticky; set by wr_underrun or wr_error
cmd_clk, wr_clk  out  1  both driven from clk
cmd_en  out  1  one-cycle command strobe
cmd_instr  out  3  constant 3'b000 (write)
cmd_bl  out  6  words in burst minus 1
cmd_byte_addr  out  30  burst start byte address
cmd_full  in  1  MCB command FIFO full
wr_en  out  1  one-cycle write-FIFO push
wr_data  out  32  packed word; byte0 in [7:0]
wr_mask  out  4  1 = lane masked
wr_full  in  1  MCB write FIFO full
wr_underrun, wr_error  in  1  MCB write-path fault flags
(cmd_empty, wr_empty, wr_count are unused and left unconnected at the instance)

Behaviour:
- Reset values:
  - Outputs: cmd_en=0, wr_en=0, wr_data=0, wr_mask=0, cmd_bl=0, cmd_byte_addr=BASE_ADDR, error=0, byte_ready=0, busy=0.
  - Internal: byte_idx=0, word_cnt=0, state=ST_FILL.
- Reset mid-operation:
  - Everything is cleared immediately.
  - Words already in the MCB FIFO are not retracted; reset of the MCB is handled separately.
- States: ST_FILL, ST_PUSH, ST_CMD, ST_HALT.
- ST_FILL:
  - byte_ready=1.
  - An accepted byte is stored in lane byte_idx, and byte_idx increments modulo 4.
  - On acceptance of lane 3: the word is latched with wr_mask=4'b0000 and the state moves to ST_PUSH.
- ST_PUSH:
  - byte_ready=0.
  - If !wr_full: wr_en=1 for exactly one cycle and word_cnt++.
  - Next state is ST_CMD if word_cnt+1==BURST_LEN or a flush is pending; otherwise ST_FILL.
  - If wr_full: hold wr_data and wr_mask, and wait.
- Flush, latched into flush_pend:
  - If byte_idx!=0: the partial word is latched with unfilled lanes masked (e.g. byte_idx=1 gives wr_mask=4'b1110), then ST_PUSH.
  - Else if word_cnt!=0: go to ST_CMD.
  - Else (nothing buffered): the flush is ignored.
- Flush on the same cycle as an accepted byte: the byte is stored first, then the flush applies, including that byte.
- ST_CMD:
  - Wait while cmd_full.
  - Otherwise: cmd_en=1 for one cycle, cmd_bl=word_cnt-1, cmd_byte_addr=cur_addr.
  - Then cur_addr += word_cnt*4. If the result is >= ADDR_LIMIT, cur_addr becomes BASE_ADDR (no partial-range split).
  - Clear word_cnt and flush_pend, then return to ST_FILL.
- Ordering rule: every word of a burst is pushed (wr_en) before its cmd_en. A command is never issued with word_cnt==0.
- Latency: the wr_en for a full word occurs 1 cycle after the 4th byte is accepted, when wr_full=0. cmd_en follows 1 cycle after the last wr_en, when cmd_full=0.
- ST_HALT:
  - wr_underrun or wr_error in any state sets error and forces ST_HALT.
  - In ST_HALT: byte_ready=0, no strobes are issued, and the block stays there until reset.
- Address arithmetic is 30-bit unsigned. cur_addr is always 4-byte aligned.

Optional Feature:
- Macro: UART_MCB_BURST_WRITER_STATS_EN.
- Defined:
  - Adds output burst_count [15:0], incremented on every cmd_en and wrapping 16'hFFFF to 0.
  - Adds output addr_wrap [0:0], a sticky flag set on the first address wrap.
  - Both reset to 0.
- Undefined: neither port nor its logic exists.

Decomposition:
- Shared package/header uart_mcb_pkg:
  - State encodings ST_FILL, ST_PUSH, ST_CMD, ST_HALT.
  - MCB_INSTR_WRITE=3'b000, MCB_INSTR_READ=3'b001.
  - MCB_MAX_BL=64.
- One natural sub-module, byte_word_packer: holds lane storage, byte_idx and mask generation, and outputs word, mask and word_done.
- The FSM, address counter and MCB strobes stay in the top module.

Test Plan:
- BURST_LEN=4; bytes 01..10 (16 bytes) with cmd_full=0 and wr_full=0 -> four wr_en with wr_data 04030201, 08070605, 0C0B0A09, 100F0E0D, mask 0; then one cmd_en with bl=3 and addr=0.
- Same sequence repeated -> second cmd_en with addr=0x10.
- Bytes AA, BB, then flush -> wr_en with data 0000BBAA and mask 1100; cmd_en with bl=0.
- Hold wr_full=1 for 5 cycles at a word boundary -> wr_en deferred, wr_data stable, byte_ready=0; cmd_full=1 held -> cmd_en waits and fires the cycle after it clears.
- ADDR_LIMIT=0x20, BURST_LEN=4: third burst -> addr=0x00 after 0x00 and 0x10 (with STATS: addr_wrap=1, burst_count=3).
- Pulse wr_error mid-burst -> error=1, no further wr_en/cmd_en; assert reset mid-ST_PUSH -> all outputs at reset values.
